// File: rtl/tt_revanth_pkg.sv
// Shared types and constants for the byte-serial wide subtractor.
// Holds the FSM state encoding, the default operand width and the uio bit map.
package tt_revanth_pkg;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int NBYTES_DEFAULT = 4;

  // uio_in control bits
  localparam int UIO_IN_VALID = 0;
  localparam int UIO_OP       = 1;
  localparam int UIO_RD_NEXT  = 2;
  localparam int UIO_CLEAR    = 3;
  // uio_out status bits
  localparam int UIO_BUSY     = 4;
  localparam int UIO_DONE     = 5;
  localparam int UIO_BORROW   = 6;
  localparam int UIO_ZERO     = 7;

  function automatic logic byte_is_zero(input logic [7:0] value);
    return (value == 8'h00);
  endfunction

endpackage

// File: rtl/tt_revanth_sub_byte.sv
// One 8-bit slice of the wide subtractor: d = x - y - bin, with borrow out.
module tt_revanth_sub_byte (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       bin,
  output logic [7:0] d,
  output logic       bout
);

  logic [8:0] full;

  // A 9-bit difference exposes the borrow in its top bit.
  assign full = {1'b0, x} - {1'b0, y} - {8'h00, bin};
  assign d    = full[7:0];
  assign bout = full[8];

endmodule

// File: rtl/tt_um_revanth_wide_sub.sv
// Byte-serial NBYTES-wide subtractor (A-B or B-A), one byte per cycle through a shared slice.
// Define WIDE_SUB_SATURATE_EN to clamp negative results to zero.
module tt_um_revanth_wide_sub
  import tt_revanth_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST     = CW'(NBYTES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef WIDE_SUB_SATURATE_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic in_valid, op_in, rd_next, clear;
  logic unused_bits;

  assign in_valid    = uio_in[UIO_IN_VALID];
  assign op_in       = uio_in[UIO_OP];
  assign rd_next     = uio_in[UIO_RD_NEXT];
  assign clear       = uio_in[UIO_CLEAR];
  assign unused_bits = &{1'b0, uio_in[7:4]};

  logic [1:0] rst_sync;
  logic       core_rst_n;

  // Reset asserts immediately but releases only after two clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign core_rst_n = rst_sync[1];

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CW-1:0] rp, rp_nx;
  logic          op_lat, op_lat_nx;
  logic          done, done_nx;
  logic          borrow, borrow_nx;
  logic          zero, zero_nx;
  logic          chain, chain_nx;
  logic          zacc, zacc_nx;
  logic          wr_a, wr_b, wr_res;
  logic [CW-1:0] wr_idx;

  logic [7:0] a_mem   [NBYTES];
  logic [7:0] b_mem   [NBYTES];
  logic [7:0] res_mem [NBYTES];

  logic [7:0] sub_x, sub_y, sub_d;
  logic       sub_bout;

  assign sub_x = op_lat ? b_mem[cnt] : a_mem[cnt];
  assign sub_y = op_lat ? a_mem[cnt] : b_mem[cnt];

  tt_revanth_sub_byte u_sub (
    .x    (sub_x),
    .y    (sub_y),
    .bin  (chain),
    .d    (sub_d),
    .bout (sub_bout)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state <= LOAD_A;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state, counters, flags and store write enables.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    rp_nx     = rp;
    op_lat_nx = op_lat;
    done_nx   = done;
    borrow_nx = borrow;
    zero_nx   = zero;
    chain_nx  = chain;
    zacc_nx   = zacc;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    wr_res    = 1'b0;
    wr_idx    = cnt;
    if (!ena) begin
      state_nx = state;
    end else if (clear) begin
      state_nx  = LOAD_A;
      cnt_nx    = CNT_ZERO;
      done_nx   = 1'b0;
      borrow_nx = 1'b0;
      zero_nx   = 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (in_valid) begin
            wr_a = 1'b1;
            if (cnt == CNT_ZERO) begin
              op_lat_nx = op_in;
            end else begin
              op_lat_nx = op_lat;
            end
            if (cnt == LAST) begin
              cnt_nx   = CNT_ZERO;
              state_nx = LOAD_B;
            end else begin
              cnt_nx = cnt + CNT_ONE;
            end
          end else begin
            cnt_nx = cnt;
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            wr_b = 1'b1;
            if (cnt == LAST) begin
              cnt_nx   = CNT_ZERO;
              state_nx = COMPUTE;
              chain_nx = 1'b0;
              zacc_nx  = 1'b1;
            end else begin
              cnt_nx = cnt + CNT_ONE;
            end
          end else begin
            cnt_nx = cnt;
          end
        end
        COMPUTE: begin
          wr_res   = 1'b1;
          chain_nx = sub_bout;
          zacc_nx  = zacc & byte_is_zero(sub_d);
          if (cnt == LAST) begin
            state_nx  = DONE;
            cnt_nx    = CNT_ZERO;
            rp_nx     = CNT_ZERO;
            done_nx   = 1'b1;
            borrow_nx = sub_bout;
            // A clamped negative result reads as all-zero bytes.
            if (SAT_EN && sub_bout) begin
              zero_nx = 1'b1;
            end else begin
              zero_nx = zacc & byte_is_zero(sub_d);
            end
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        DONE: begin
          if (in_valid) begin
            wr_a      = 1'b1;
            wr_idx    = CNT_ZERO;
            op_lat_nx = op_in;
            done_nx   = 1'b0;
            borrow_nx = 1'b0;
            zero_nx   = 1'b0;
            if (LAST == CNT_ZERO) begin
              state_nx = LOAD_B;
              cnt_nx   = CNT_ZERO;
            end else begin
              state_nx = LOAD_A;
              cnt_nx   = CNT_ONE;
            end
          end else if (rd_next) begin
            if (rp == LAST) begin
              rp_nx = CNT_ZERO;
            end else begin
              rp_nx = rp + CNT_ONE;
            end
          end else begin
            rp_nx = rp;
          end
        end
        default: begin
          state_nx = LOAD_A;
          cnt_nx   = CNT_ZERO;
        end
      endcase
    end
  end

  // Counters, latched op and status flags.
  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      cnt    <= CNT_ZERO;
      rp     <= CNT_ZERO;
      op_lat <= 1'b0;
      done   <= 1'b0;
      borrow <= 1'b0;
      zero   <= 1'b0;
      chain  <= 1'b0;
      zacc   <= 1'b0;
    end else begin
      cnt    <= cnt_nx;
      rp     <= rp_nx;
      op_lat <= op_lat_nx;
      done   <= done_nx;
      borrow <= borrow_nx;
      zero   <= zero_nx;
      chain  <= chain_nx;
      zacc   <= zacc_nx;
    end
  end

  // Operand and result byte stores.
  always_ff @(posedge clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      for (int i = 0; i < NBYTES; i++) begin
        a_mem[i]   <= 8'h00;
        b_mem[i]   <= 8'h00;
        res_mem[i] <= 8'h00;
      end
    end else begin
      if (wr_a) begin
        a_mem[wr_idx] <= ui_in;
      end
      if (wr_b) begin
        b_mem[wr_idx] <= ui_in;
      end
      if (wr_res) begin
        res_mem[wr_idx] <= sub_d;
      end
    end
  end

  logic busy;

  assign busy = (state == LOAD_B) || (state == COMPUTE) ||
                ((state == LOAD_A) && (cnt != CNT_ZERO));

  // Result byte is only visible once the whole difference is complete.
  always_comb begin
    uo_out = 8'h00;
    if (done && !(SAT_EN && borrow)) begin
      uo_out = res_mem[rp];
    end else begin
      uo_out = 8'h00;
    end
  end

  // Status byte assembly.
  always_comb begin
    uio_out             = 8'h00;
    uio_out[UIO_BUSY]   = busy;
    uio_out[UIO_DONE]   = done;
    uio_out[UIO_BORROW] = borrow;
    uio_out[UIO_ZERO]   = zero;
  end

  assign uio_oe = 8'hF0;

endmodule

// File: tb/tb_tt_um_revanth_wide_sub.sv
// Directed, table-driven bench for tt_um_revanth_wide_sub with NBYTES=4.
module tb_tt_um_revanth_wide_sub;

  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  always #5 clk = ~clk;

  tt_um_revanth_wide_sub #(.NBYTES(NB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          op;
    logic [31:0] res;
    bit          bo;
    bit          z;
    bit          noise;
  } vec_t;

  vec_t vt[7];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit valid, input bit opb, input bit rd, input bit clr, input logic [7:0] d);
    ui_in  = d;
    uio_in = {4'b0000, clr, rd, opb, valid};
  endtask

  task automatic send(input logic [7:0] d, input bit opb);
    drive(1'b1, opb, 1'b0, 1'b0, d);
    tick();
    drive(1'b0, opb, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_clear();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b, input bit opb, input int first);
    for (int i = first; i < NB; i++) send(a[8*i +: 8], opb);
    for (int i = 0; i < NB; i++) send(b[8*i +: 8], opb);
  endtask

  task automatic wait_done(input string name, input bit noise);
    int n;
    n = 0;
    chk({name, " busy_compute"}, {31'd0, uio_out[4]}, 32'd1);
    if (noise) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
    while (!uio_out[5] && n < 12) begin
      tick();
      n++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk({name, " done_latency"}, n, 32'd4);
  endtask

  task automatic check_result(input string name, input logic [31:0] r, input bit bo, input bit z);
    chk({name, " borrow"}, {31'd0, uio_out[6]}, {31'd0, bo});
    chk({name, " zero"}, {31'd0, uio_out[7]}, {31'd0, z});
    chk({name, " busy_done"}, {31'd0, uio_out[4]}, 32'd0);
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("%s byte%0d", name, i), {24'd0, uo_out}, {24'd0, r[8*i +: 8]});
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] er;
    bit eb, ez;

    vt[0] = '{32'h00001234, 32'h00000234, 1'b0, 32'h00001000, 1'b0, 1'b0, 1'b0};
    vt[1] = '{32'h00000001, 32'h00000002, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vt[2] = '{32'h00000005, 32'h00000003, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
    vt[3] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vt[4] = '{32'h01000000, 32'h00000001, 1'b0, 32'h00FFFFFF, 1'b0, 1'b0, 1'b1};
    vt[5] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0};
    vt[6] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};

    tick();
    tick();
    chk("reset uo_out", {24'd0, uo_out}, 32'h00);
    chk("reset uio_out", {24'd0, uio_out}, 32'h00);
    chk("reset uio_oe", {24'd0, uio_oe}, 32'hF0);
    rst_n = 1'b1;
    ena   = 1'b1;
    tick();
    tick();
    tick();
    chk("post-reset uio_out", {24'd0, uio_out}, 32'h00);

    for (int v = 0; v < 7; v++) begin
      er = vt[v].res;
      eb = vt[v].bo;
      ez = vt[v].z;
`ifdef WIDE_SUB_SATURATE_EN
      if (eb) begin
        er = 32'h00000000;
        ez = 1'b1;
      end
`endif
      do_clear();
      load(vt[v].a, vt[v].b, vt[v].op, 0);
      wait_done($sformatf("v%0d", v), vt[v].noise);
      check_result($sformatf("v%0d", v), er, eb, ez);
    end

    // Read pointer wraps: 4 pulses already issued, 5 more lands on byte 1.
    do_clear();
    load(32'h00001234, 32'h00000234, 1'b0, 0);
    wait_done("wrap", 1'b0);
    check_result("wrap", 32'h00001000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("wrap rp=1", {24'd0, uo_out}, 32'h10);

    // ena low freezes everything, including rd_next and in_valid.
    ena = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h77);
    tick();
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("ena hold uo_out", {24'd0, uo_out}, 32'h10);
    chk("ena hold done", {31'd0, uio_out[5]}, 32'd1);
    ena = 1'b1;

    // rd_next with in_valid in DONE starts a new operation with A[0].
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("restart done", {31'd0, uio_out[5]}, 32'd0);
    chk("restart busy", {31'd0, uio_out[4]}, 32'd1);
    load(32'h80000000, 32'h7FFFFFFF, 1'b0, 1);
    wait_done("restart", 1'b0);
    check_result("restart", 32'h00000001, 1'b0, 1'b0);

    // clear in LOAD_B, then clear with in_valid drops the byte.
    do_clear();
    for (int i = 0; i < NB; i++) send(8'hFF, 1'b0);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    chk("loadb busy", {31'd0, uio_out[4]}, 32'd1);
    do_clear();
    chk("clear busy", {31'd0, uio_out[4]}, 32'd0);
    chk("clear uio_out", {24'd0, uio_out}, 32'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h55);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("clear+valid busy", {31'd0, uio_out[4]}, 32'd0);
    load(32'h00000100, 32'h00000001, 1'b0, 0);
    wait_done("after clear", 1'b0);
    check_result("after clear", 32'h000000FF, 1'b0, 1'b0);

    // Reset with a visible result hides it at once.
    rst_n = 1'b0;
    #1;
    chk("reset in DONE uo_out", {24'd0, uo_out}, 32'h00);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();

    // Reset mid-COMPUTE, no clock edge needed for outputs to clear.
    load(32'h00001234, 32'h00000234, 1'b0, 0);
    tick();
    tick();
    chk("mid compute busy", {31'd0, uio_out[4]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid reset uo_out", {24'd0, uo_out}, 32'h00);
    chk("mid reset uio_out", {24'd0, uio_out}, 32'h00);
    chk("mid reset uio_oe", {24'd0, uio_oe}, 32'hF0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("after reset uio_out", {24'd0, uio_out}, 32'h00);
    load(32'h00000010, 32'h00000001, 1'b0, 0);
    wait_done("fresh", 1'b0);
    check_result("fresh", 32'h0000000F, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
